// File: rtl/risc_pkg.sv
// Shared RISC definitions: NOP encoding, opcode field position, default immediate width.
package risc_pkg;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned IMM_W_DEF   = 4;
  localparam int unsigned OPC_MSB     = 15;
  localparam int unsigned OPC_LSB     = 12;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 16'hF000;
endpackage

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, imem req/ack handshake, instruction register.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_stage
  import risc_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        INSTR_W     = 16,
  parameter int unsigned        IMM_W       = IMM_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int unsigned        TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [IMM_W-1:0]   imm_field,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               fetch_err
);

  localparam logic S_FETCH = 1'b0;
  localparam logic S_ISSUE = 1'b1;

  logic               state_q, state_d;
  logic               req_en_q;   // low for the first cycle after reset so a stale ack is ignored
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               ack_fire;
  logic               timeout;

  assign ack_fire = imem_req & imem_ack;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;

  assign timeout = imem_req & ~imem_ack & (wdog_q == TIMEOUT_CYC[7:0]);

  // Watchdog counts request cycles, restarts on ack or on timeout; error is sticky
  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q | timeout;
    if (ack_fire || timeout) wdog_d = '0;
    else if (imem_req)       wdog_d = wdog_q + 8'd1;
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC[7:0];
  assign timeout    = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      req_en_q <= 1'b0;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      req_en_q <= 1'b1;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Next state: fetch completes on ack (or timeout), issue leaves when decode accepts
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (ack_fire || timeout) state_d = S_ISSUE;
      S_ISSUE: if (!stall)              state_d = S_FETCH;
      default:                          state_d = S_FETCH;
    endcase
  end

  // Datapath next values: latch IR on ack, advance PC, apply redirect on issue
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    if (state_q == S_FETCH) begin
      if (ack_fire || timeout) begin
        ir_d     = ack_fire ? imem_rdata : NOP_INSTR[INSTR_W-1:0];
        pc_out_d = pc_q;
        pc_d     = pc_q + 1'b1;
      end
    end else if (!stall && branch_taken) begin
      pc_d = branch_target;
    end
  end

  // Outputs decoded from state
  always_comb begin
    imem_req    = (state_q == S_FETCH) & req_en_q;
    instr_valid = (state_q == S_ISSUE);
  end

  assign imem_addr = pc_q;
  assign instr     = ir_q;
  assign imm_field = ir_q[IMM_W-1:0];
  assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; checks FETCH_TIMEOUT_EN path when defined.
module tb_instr_fetch_stage;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  imm_field;
  logic [15:0] pc_out;
  logic        fetch_err;

  // second instance: RESET_PC at top of address space, memory always acks
  logic        rst2_n = 1'b0;
  logic        req2, vld2, err2;
  logic [15:0] addr2, instr2, pc_out2;
  logic [3:0]  imm2;
  logic        ack2;
  assign ack2 = req2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  instr_fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .imm_field(imm_field),
    .pc_out(pc_out), .fetch_err(fetch_err)
  );

  instr_fetch_stage #(.RESET_PC(16'hFFFF)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(16'hBEEF), .imem_ack(ack2), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(16'h0000),
    .instr_valid(vld2), .instr(instr2), .imm_field(imm2),
    .pc_out(pc_out2), .fetch_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic nclk(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset state
    nclk(2);
    chk("rst_req", imem_req, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_err", fetch_err, 0);

    // 1: zero-wait fetch
    rst_n = 1'b1;
    nclk();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 16'h0000);
    chk("t1_vld0", instr_valid, 0);
    imem_ack = 1'b1; imem_rdata = 16'hA123;
    nclk();
    imem_ack = 1'b0;
    chk("t1_vld", instr_valid, 1);
    chk("t1_instr", instr, 16'hA123);
    chk("t1_imm", imm_field, 4'h3);
    chk("t1_pc_out", pc_out, 16'h0000);
    chk("t1_req_low", imem_req, 0);
    nclk();
    chk("t1_next_addr", imem_addr, 16'h0001);
    chk("t1_vld_drop", instr_valid, 0);

    // 2: three wait cycles, request and address held
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_hold", imem_req, 1);
      chk("t2_addr_hold", imem_addr, 16'h0001);
      chk("t2_no_vld", instr_valid, 0);
      nclk();
    end
    chk("t2_req_ack_cyc", imem_req, 1);
    chk("t2_addr_ack_cyc", imem_addr, 16'h0001);
    imem_ack = 1'b1; imem_rdata = 16'h5B7C;
    nclk();
    chk("t2_vld", instr_valid, 1);
    chk("t2_instr", instr, 16'h5B7C);
    chk("t2_imm", imm_field, 4'hC);
    chk("t2_pc_out", pc_out, 16'h0001);

    // 3: stall with branch pending; ack in issue must be ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    imem_rdata = 16'hDEAD;  // ack still high
    for (int i = 0; i < 5; i++) begin
      nclk();
      chk("t3_vld", instr_valid, 1);
      chk("t3_instr", instr, 16'h5B7C);
      chk("t3_pc_out", pc_out, 16'h0001);
      chk("t3_no_req", imem_req, 0);
    end
    imem_ack = 1'b0;
    stall = 1'b0;
    nclk();
    branch_taken = 1'b0;
    chk("t3_br_req", imem_req, 1);
    chk("t3_br_addr", imem_addr, 16'h0040);
    chk("t3_br_vld", instr_valid, 0);

    // 5: async reset mid-handshake with a stale ack held across release
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req", imem_req, 0);
    chk("t5_vld", instr_valid, 0);
    chk("t5_instr", instr, 0);
    chk("t5_pc_out", pc_out, 0);
    nclk();
    rst_n = 1'b1;
    nclk();
    chk("t5_stale_ign", instr_valid, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 16'h0000);
    imem_ack = 1'b0;
    nclk();
    imem_ack = 1'b1; imem_rdata = 16'h0ED1;
    nclk();
    imem_ack = 1'b0;
    chk("t5_instr2", instr, 16'h0ED1);
    chk("t5_pc_out2", pc_out, 16'h0000);
    chk("t5_vld2", instr_valid, 1);
    nclk();
    chk("t5_next_addr", imem_addr, 16'h0001);

`ifdef FETCH_TIMEOUT_EN
    // 6: no ack, watchdog forces NOP
    begin
      int waited = 0;
      while (!instr_valid && waited < 40) begin
        nclk();
        waited++;
      end
      chk("t6_timeout_seen", instr_valid, 1);
      chk("t6_instr_nop", instr, NOP_INSTR);
      chk("t6_err", fetch_err, 1);
      chk("t6_pc_out", pc_out, 16'h0001);
      nclk();
      chk("t6_next_addr", imem_addr, 16'h0002);
      imem_ack = 1'b1; imem_rdata = 16'h2222;
      nclk();
      imem_ack = 1'b0;
      chk("t6_instr_ok", instr, 16'h2222);
      chk("t6_err_sticky", fetch_err, 1);
    end
`else
    // no watchdog: fetch waits indefinitely and error stays low
    nclk(30);
    chk("t6_still_waiting", imem_req, 1);
    chk("t6_no_vld", instr_valid, 0);
    chk("t6_err_off", fetch_err, 0);
`endif

    // 4: PC wrap from FFFF
    rst2_n = 1'b1;
    nclk(2);
    chk("t4_vld_a", vld2, 1);
    chk("t4_pc_out_a", pc_out2, 16'hFFFF);
    chk("t4_instr_a", instr2, 16'hBEEF);
    nclk(2);
    chk("t4_vld_b", vld2, 1);
    chk("t4_pc_out_b", pc_out2, 16'h0000);
    chk("t4_err", err2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
